// File: rtl/sync_fifo_ctrl_pkg.sv
// sync_fifo_ctrl_pkg: read-mode encodings and threshold defaults shared by the FIFO family.
package sync_fifo_ctrl_pkg;
    localparam int FIFO_MODE_STD      = 0;
    localparam int FIFO_MODE_FWFT     = 1;
    localparam int AEMPTY_THR_DEFAULT = 2;
    function automatic int afull_thr_default(input int depth);
        return depth - 2;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: register-array storage, synchronous write, asynchronous read, storage not reset.
module fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with FWFT/standard read modes, level and sticky error flags.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 8,
    parameter int FWFT       = FIFO_MODE_FWFT,
    parameter int AFULL_THR  = afull_thr_default(DEPTH),
    parameter int AEMPTY_THR = AEMPTY_THR_DEFAULT,
    parameter int PTR_SZ     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              full_o,
    output logic              afull_o,
    input  logic              rd_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              valid_o,
    output logic              empty_o,
    output logic              aempty_o,
    output logic [PTR_SZ:0]   level_o,
    output logic              ovf_o,
    output logic              udf_o
);
    localparam logic [PTR_SZ:0] DEPTH_L  = (PTR_SZ+1)'(DEPTH);
    localparam logic [PTR_SZ:0] AFULL_L  = (PTR_SZ+1)'(AFULL_THR);
    localparam logic [PTR_SZ:0] AEMPTY_L = (PTR_SZ+1)'(AEMPTY_THR);

    logic [PTR_SZ:0]  wrptr_q, wrptr_d, rdptr_q, rdptr_d;
    logic             ovf_q, ovf_d, udf_q, udf_d, valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d, rdata;
    logic             wr_en, rd_en;

    fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wrptr_q[PTR_SZ-1:0]),
        .wdata_i (data_i),
        .raddr_i (rdptr_q[PTR_SZ-1:0]),
        .rdata_o (rdata)
    );

    assign level_o  = wrptr_q - rdptr_q;
    assign full_o   = level_o == DEPTH_L;
    assign empty_o  = level_o == '0;
    assign afull_o  = level_o >= AFULL_L;
    assign aempty_o = level_o <= AEMPTY_L;
    // flush wins over both requests, so a write during clr_i is neither stored nor flagged
    assign wr_en    = wr_i && !full_o && !clr_i;
    assign rd_en    = rd_i && !empty_o && !clr_i;
    assign valid_o  = (FWFT == FIFO_MODE_FWFT) ? !empty_o : valid_q;
    assign data_o   = (FWFT == FIFO_MODE_FWFT) ? rdata : data_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

    always_comb begin
        wrptr_d = clr_i ? '0 : wrptr_q + (PTR_SZ+1)'(wr_en);
        rdptr_d = clr_i ? '0 : rdptr_q + (PTR_SZ+1)'(rd_en);
        ovf_d   = !clr_i && (ovf_q || (wr_i && full_o));
        udf_d   = !clr_i && (udf_q || (rd_i && empty_o));
        valid_d = rd_en;
        data_d  = rd_en ? rdata : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed scoreboard bench for FWFT and standard-mode FIFO instances.
module tb_sync_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_f = 1'b0, rd_f = 1'b0, clr_f = 1'b0;
    logic [7:0] d_f = '0;
    logic       wr_s = 1'b0, rd_s = 1'b0, clr_s = 1'b0;
    logic [7:0] d_s = '0;
    logic       full_f, afull_f, valid_f, empty_f, aempty_f, ovf_f, udf_f;
    logic       full_s, afull_s, valid_s, empty_s, aempty_s, ovf_s, udf_s;
    logic [7:0] data_f, data_s;
    logic [3:0] level_f, level_s;
    logic [7:0] q [$];
    logic [7:0] qs [$];
    int         mlev = 0;
    int         n = 0;
    int         nf = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DEPTH(8), .WIDTH(8), .FWFT(1)) u_f (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_f), .wr_i(wr_f), .data_i(d_f),
        .full_o(full_f), .afull_o(afull_f), .rd_i(rd_f), .data_o(data_f),
        .valid_o(valid_f), .empty_o(empty_f), .aempty_o(aempty_f),
        .level_o(level_f), .ovf_o(ovf_f), .udf_o(udf_f)
    );

    sync_fifo_ctrl #(.DEPTH(8), .WIDTH(8), .FWFT(0)) u_s (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_s), .wr_i(wr_s), .data_i(d_s),
        .full_o(full_s), .afull_o(afull_s), .rd_i(rd_s), .data_o(data_s),
        .valid_o(valid_s), .empty_o(empty_s), .aempty_o(aempty_s),
        .level_o(level_s), .ovf_o(ovf_s), .udf_o(udf_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FWFT pops at the edge where rd && valid; standard mode presents popped data while valid_o is high
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_f && !clr_f && valid_f) begin
                if (q.size() == 0) begin
                    n++;
                    nf++;
                    $display("FAIL pop_f: got %0h expected no data", data_f);
                end else chk("pop_f", data_f, q.pop_front());
            end
            if (valid_s) begin
                if (qs.size() == 0) begin
                    n++;
                    nf++;
                    $display("FAIL pop_s: got %0h expected no data", data_s);
                end else chk("pop_s", data_s, qs.pop_front());
            end
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c = 1'b0);
        wr_f = w; d_f = d; rd_f = r; clr_f = c;
        if (c) begin
            q.delete();
            mlev = 0;
        end else begin
            if (w && mlev < 8) q.push_back(d);
            mlev = mlev + int'(w && mlev < 8) - int'(r && mlev > 0);
        end
        @(posedge clk); #1;
        wr_f = 1'b0; rd_f = 1'b0; clr_f = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level_f, 0);
        chk("rst_empty", empty_f, 1);
        chk("rst_aempty", aempty_f, 1);
        chk("rst_full", full_f, 0);
        chk("rst_afull", afull_f, 0);
        chk("rst_valid", valid_f, 0);
        chk("rst_ovf", ovf_f, 0);
        chk("rst_udf", udf_f, 0);
        chk("rst_data_s", data_s, 0);
        chk("rst_valid_s", valid_s, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            chk("fill_level", level_f, i);
            chk("fill_afull", afull_f, i >= 6);
            chk("fill_full", full_f, i == 8);
        end
        cyc(1'b1, 8'hFF, 1'b0);
        chk("ovf_set", ovf_f, 1);
        chk("ovf_level", level_f, 8);
        // drain 0x01..0x08, then underflow
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_level", level_f, 8 - k);
            chk("drain_aempty", aempty_f, k >= 6);
            chk("drain_empty", empty_f, k == 8);
        end
        chk("drain_all_popped", q.size(), 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_set", udf_f, 1);
        chk("udf_level", level_f, 0);
        chk("udf_valid", valid_f, 0);
        chk("ovf_sticky", ovf_f, 1);
        // standard mode: registered read, one-cycle valid pulse, data holds
        wr_s = 1'b1; d_s = 8'hA5;
        @(posedge clk); #1;
        wr_s = 1'b0;
        chk("std_level", level_s, 1);
        chk("std_valid_idle", valid_s, 0);
        qs.push_back(8'hA5);
        rd_s = 1'b1;
        @(posedge clk); #1;
        rd_s = 1'b0;
        chk("std_valid", valid_s, 1);
        chk("std_data", data_s, 8'hA5);
        @(posedge clk); #1;
        chk("std_valid_drop", valid_s, 0);
        chk("std_data_hold", data_s, 8'hA5);
        rd_s = 1'b1;
        @(posedge clk); #1;
        rd_s = 1'b0;
        chk("std_udf", udf_s, 1);
        @(posedge clk); #1;
        chk("std_no_valid", valid_s, 0);
        // flush, simultaneous rd/wr on empty, then steady level 3 across pointer wraps
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_udf", udf_f, 0);
        chk("clr_ovf", ovf_f, 0);
        cyc(1'b1, 8'h10, 1'b1);
        chk("rw_empty_level", level_f, 1);
        chk("rw_empty_udf", udf_f, 1);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h12, 1'b0);
        chk("steady_level0", level_f, 3);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(8'h13 + i), 1'b1);
            chk("steady_level", level_f, 3);
        end
        // fill, overflow, rd/wr on full, then flush with a concurrent write
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        chk("t5_full", full_f, 1);
        cyc(1'b1, 8'hEE, 1'b0);
        chk("t5_ovf", ovf_f, 1);
        chk("t5_level8", level_f, 8);
        cyc(1'b1, 8'hEF, 1'b1);
        chk("rw_full_level", level_f, 7);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t5_level5", level_f, 5);
        cyc(1'b1, 8'hDD, 1'b0, 1'b1);
        chk("flush_level", level_f, 0);
        chk("flush_empty", empty_f, 1);
        chk("flush_ovf", ovf_f, 0);
        chk("flush_udf", udf_f, 0);
        chk("flush_valid", valid_f, 0);
        cyc(1'b1, 8'h55, 1'b0);
        chk("post_flush_data", data_f, 8'h55);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_flush_empty", empty_f, 1);
        // asynchronous reset mid-stream
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        chk("pre_rst_level", level_f, 4);
        chk("pre_rst_udf", udf_f, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_level", level_f, 0);
        chk("arst_empty", empty_f, 1);
        chk("arst_aempty", aempty_f, 1);
        chk("arst_full", full_f, 0);
        chk("arst_afull", afull_f, 0);
        chk("arst_valid", valid_f, 0);
        chk("arst_udf", udf_f, 0);
        chk("arst_data_s", data_s, 0);
        q.delete();
        mlev = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 8'h70, 1'b0);
        chk("post_rst_level", level_f, 1);
        chk("post_rst_valid", valid_f, 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_empty", empty_f, 1);
        chk("end_queue", q.size(), 0);
        chk("end_queue_s", qs.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
        $finish;
    end
endmodule
